// File: rtl/guess_seq_pkg.sv
// Shared types and width helpers for the sequence-guessing game.
package guess_seq_pkg;

    typedef enum logic [1:0] {
        PH_SET   = 2'd0,
        PH_GUESS = 2'd1,
        PH_WIN   = 2'd2,
        PH_LOSE  = 2'd3
    } phase_t;

    function automatic int sym_w(input int num_keys);
        return (num_keys < 2) ? 1 : $clog2(num_keys);
    endfunction

    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/guess_edge_det.sv
// Rising-edge detector: rise is high for the cycle a level input goes 0 -> 1.
module guess_edge_det #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) prev <= '0;
        else       prev <= level;
    end

    assign rise = level & ~prev;

endmodule

// File: rtl/guess_seq_game.sv
// Two-player sequence-guessing game: setter stores a secret, guesser gets MAX_TRIES attempts.
// Optional positional hit counter enabled by defining GUESS_SEQ_HITS_EN.
module guess_seq_game
    import guess_seq_pkg::*;
#(
    parameter int NUM_KEYS  = 4,
    parameter int MAX_LEN   = 7,
    parameter int MIN_LEN   = 4,
    parameter int MAX_TRIES = 3
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_KEYS-1:0]              keys,
    input  logic                             enter,
    output logic [NUM_KEYS-1:0]              nums,
    output logic [1:0]                       phase,
    output logic                             win,
    output logic                             lose,
    output logic                             equal,
    output logic                             bigger,
    output logic                             smaller,
    output logic [$clog2(MAX_TRIES+1)-1:0]   tries_left,
    output logic                             overflow,
    output logic [$clog2(MAX_LEN+1)-1:0]     hits
);

    localparam int SW = sym_w(NUM_KEYS);
    localparam int LW = len_w(MAX_LEN);
    localparam int TW = $clog2(MAX_TRIES + 1);
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    logic [NUM_KEYS:0]   rise;
    logic [NUM_KEYS-1:0] key_rise;
    logic                enter_rise;
    logic [SW-1:0]       key_idx;
    logic [SW-1:0]       secret [MAX_LEN];
    logic [SW-1:0]       guess  [MAX_LEN];
    logic [LW-1:0]       secret_len;
    logic [LW-1:0]       guess_len;
    logic                all_eq;
    logic                match;
    phase_t              state;

    guess_edge_det #(.WIDTH(NUM_KEYS + 1)) u_edge (
        .clk   (clk),
        .reset (reset),
        .level ({enter, keys}),
        .rise  (rise)
    );

    assign key_rise   = rise[NUM_KEYS-1:0];
    assign enter_rise = rise[NUM_KEYS];
    assign phase      = state;

    // Descending scan so the lowest-index pressed key wins.
    always_comb begin
        key_idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (key_rise[i]) key_idx = SW'(i);
        end
    end

    always_comb begin
        all_eq = 1'b1;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (LW'(i) < guess_len && secret[i] != guess[i]) all_eq = 1'b0;
        end
        match = (secret_len == guess_len) && all_eq;
    end

`ifdef GUESS_SEQ_HITS_EN
    logic [LW-1:0] min_len;
    logic [LW-1:0] hit_cnt;

    always_comb begin
        min_len = (secret_len < guess_len) ? secret_len : guess_len;
        hit_cnt = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (LW'(i) < min_len && secret[i] == guess[i]) hit_cnt = hit_cnt + LW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hits <= '0;
        end else if (state == PH_GUESS && key_rise == '0 && enter_rise && guess_len != '0) begin
            hits <= hit_cnt;
        end
    end
`else
    assign hits = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= PH_SET;
            nums       <= '0;
            win        <= 1'b0;
            lose       <= 1'b0;
            equal      <= 1'b0;
            bigger     <= 1'b0;
            smaller    <= 1'b0;
            tries_left <= TW'(MAX_TRIES);
            overflow   <= 1'b0;
            secret_len <= '0;
            guess_len  <= '0;
            for (int i = 0; i < MAX_LEN; i++) begin
                secret[i] <= '0;
                guess[i]  <= '0;
            end
        end else begin
            overflow <= 1'b0;
            if (state == PH_SET || state == PH_GUESS) begin
                if (key_rise != '0) begin
                    nums <= NUM_KEYS'(1) << key_idx;
                    if (state == PH_SET) begin
                        if (secret_len < LW'(MAX_LEN)) begin
                            secret[secret_len[IW-1:0]] <= key_idx;
                            secret_len                 <= secret_len + 1'b1;
                        end else begin
                            overflow <= 1'b1;
                        end
                    end else begin
                        if (guess_len < LW'(MAX_LEN)) begin
                            guess[guess_len[IW-1:0]] <= key_idx;
                            guess_len                <= guess_len + 1'b1;
                        end else begin
                            overflow <= 1'b1;
                        end
                    end
                end else if (enter_rise) begin
                    if (state == PH_SET) begin
                        if (secret_len >= LW'(MIN_LEN)) state <= PH_GUESS;
                    end else if (guess_len != '0) begin
                        equal   <= (secret_len == guess_len);
                        bigger  <= (secret_len >  guess_len);
                        smaller <= (secret_len <  guess_len);
                        if (match) begin
                            win   <= 1'b1;
                            state <= PH_WIN;
                        end else begin
                            tries_left <= tries_left - 1'b1;
                            if (tries_left == TW'(1)) begin
                                lose  <= 1'b1;
                                state <= PH_LOSE;
                            end else begin
                                guess_len <= '0;
                                for (int i = 0; i < MAX_LEN; i++) guess[i] <= '0;
                            end
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_guess_seq_game.sv
// Self-checking bench for guess_seq_game against a queue-based model of the game rules.
module tb_guess_seq_game;

    localparam int NUM_KEYS  = 4;
    localparam int MAX_LEN   = 7;
    localparam int MIN_LEN   = 4;
    localparam int MAX_TRIES = 3;
`ifdef GUESS_SEQ_HITS_EN
    localparam bit HITS_EN = 1'b1;
`else
    localparam bit HITS_EN = 1'b0;
`endif

    typedef struct packed {
        logic [1:0] phase;
        logic [3:0] nums;
        logic       win;
        logic       lose;
        logic       equal;
        logic       bigger;
        logic       smaller;
        logic [1:0] tries;
        logic       overflow;
        logic [2:0] hits;
    } exp_t;
    localparam int EW = $bits(exp_t);

    logic       clk;
    logic       reset;
    logic [3:0] keys;
    logic       enter;
    logic [3:0] nums;
    logic [1:0] phase;
    logic       win, lose, equal, bigger, smaller, overflow;
    logic [1:0] tries_left;
    logic [2:0] hits;

    guess_seq_game #(
        .NUM_KEYS(NUM_KEYS), .MAX_LEN(MAX_LEN), .MIN_LEN(MIN_LEN), .MAX_TRIES(MAX_TRIES)
    ) dut (
        .clk(clk), .reset(reset), .keys(keys), .enter(enter),
        .nums(nums), .phase(phase), .win(win), .lose(lose),
        .equal(equal), .bigger(bigger), .smaller(smaller),
        .tries_left(tries_left), .overflow(overflow), .hits(hits)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_err = 0;
    logic [EW-1:0] exp_q[$];

    // reference model state
    int         m_phase, m_tries, m_hits;
    logic [3:0] m_nums;
    bit         m_win, m_lose, m_eq, m_big, m_small, m_ovf;
    int         sec_q[$];
    int         gss_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_tries = MAX_TRIES; m_hits = 0; m_nums = '0;
        m_win = 0; m_lose = 0; m_eq = 0; m_big = 0; m_small = 0; m_ovf = 0;
        sec_q.delete();
        gss_q.delete();
    endtask

    task automatic model_event(input logic [3:0] kv, input logic en);
        int k, ls, lg, mn, hc;
        m_ovf = 0;
        if (m_phase >= 2) return;
        if (kv != 0) begin
            k = 0;
            for (int i = NUM_KEYS - 1; i >= 0; i--) if (kv[i]) k = i;
            m_nums = 4'(1 << k);
            if (m_phase == 0) begin
                if (sec_q.size() < MAX_LEN) sec_q.push_back(k); else m_ovf = 1;
            end else begin
                if (gss_q.size() < MAX_LEN) gss_q.push_back(k); else m_ovf = 1;
            end
        end else if (en) begin
            if (m_phase == 0) begin
                if (sec_q.size() >= MIN_LEN) m_phase = 1;
            end else if (gss_q.size() > 0) begin
                ls = sec_q.size();
                lg = gss_q.size();
                m_eq = (ls == lg); m_big = (ls > lg); m_small = (ls < lg);
                mn = (ls < lg) ? ls : lg;
                hc = 0;
                for (int i = 0; i < mn; i++) if (sec_q[i] == gss_q[i]) hc++;
                m_hits = HITS_EN ? hc : 0;
                if (m_eq && hc == lg) begin
                    m_win = 1; m_phase = 2;
                end else begin
                    m_tries--;
                    if (m_tries == 0) begin
                        m_lose = 1; m_phase = 3;
                    end else begin
                        gss_q.delete();
                    end
                end
            end
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.phase = 2'(m_phase); e.nums = m_nums; e.win = m_win; e.lose = m_lose;
        e.equal = m_eq; e.bigger = m_big; e.smaller = m_small;
        e.tries = 2'(m_tries); e.overflow = m_ovf; e.hits = 3'(m_hits);
        exp_q.push_back(e);
    endtask

    task automatic compare_out();
        exp_t e;
        e = exp_t'(exp_q.pop_front());
        check("phase",      32'(phase),      32'(e.phase));
        check("nums",       32'(nums),       32'(e.nums));
        check("win",        32'(win),        32'(e.win));
        check("lose",       32'(lose),       32'(e.lose));
        check("equal",      32'(equal),      32'(e.equal));
        check("bigger",     32'(bigger),     32'(e.bigger));
        check("smaller",    32'(smaller),    32'(e.smaller));
        check("tries_left", 32'(tries_left), 32'(e.tries));
        check("overflow",   32'(overflow),   32'(e.overflow));
        check("hits",       32'(hits),       32'(e.hits));
    endtask

    // driver tasks
    task automatic do_reset();
        keys = '0; enter = 1'b0; reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        push_exp();
        compare_out();
    endtask

    task automatic step(input logic [3:0] kv, input logic en);
        @(negedge clk);
        keys = kv; enter = en;
        model_event(kv, en);
        push_exp();
        @(posedge clk); #1;
        compare_out();
        @(negedge clk);
        keys = '0; enter = 1'b0;
        m_ovf = 0;
        push_exp();
        @(posedge clk); #1;
        compare_out();
    endtask

    task automatic press(input int k);
        step(4'(1 << k), 1'b0);
    endtask

    task automatic commit();
        step(4'b0000, 1'b1);
    endtask

    task automatic enter_secret_0123();
        for (int i = 0; i < 4; i++) press(i);
        commit();
    endtask

    function automatic logic [3:0] rand_keys();
        if ($urandom_range(0, 3) == 0) return 4'($urandom_range(1, 15));
        return 4'(1 << $urandom_range(0, 3));
    endfunction

    task automatic random_game();
        int n;
        do_reset();
        n = $urandom_range(1, 8);
        for (int i = 0; i < n; i++) step(rand_keys(), 1'($urandom_range(0, 7) == 0));
        commit();
        for (int i = 0; i < 8 && m_phase == 0; i++) begin
            press($urandom_range(0, 3));
            commit();
        end
        for (int g = 0; g < 4; g++) begin
            if ($urandom_range(0, 2) == 0) begin
                n = sec_q.size();
                for (int i = 0; i < n; i++) press(sec_q[i]);
            end else begin
                n = $urandom_range(0, 8);
                for (int i = 0; i < n; i++) step(rand_keys(), 1'($urandom_range(0, 9) == 0));
            end
            commit();
        end
        for (int i = 0; i < 3; i++) step(rand_keys(), 1'($urandom_range(0, 1)));
    endtask

    initial begin
        reset = 1'b1; keys = '0; enter = 1'b0;

        // correct first guess
        do_reset();
        enter_secret_0123();
        for (int i = 0; i < 4; i++) press(i);
        commit();

        // short guess, then retry starts from position 0
        do_reset();
        enter_secret_0123();
        for (int i = 0; i < 3; i++) press(i);
        commit();
        for (int i = 0; i < 4; i++) press(i);
        commit();

        // three wrong guesses, then terminal state ignores keys
        do_reset();
        enter_secret_0123();
        for (int g = 0; g < 3; g++) begin
            for (int i = 0; i < 4; i++) press(3);
            commit();
        end
        press(1);
        commit();

        // too-short secret ignored; overflow on 8th key
        do_reset();
        for (int i = 0; i < 3; i++) press(i);
        commit();
        for (int i = 0; i < 5; i++) press(i % 4);
        commit();

        // simultaneous edges
        do_reset();
        step(4'b0101, 1'b0);
        step(4'b0100, 1'b1);
        step(4'b1010, 1'b0);
        step(4'b1000, 1'b1);
        commit();

        // asynchronous reset mid-guess, then a fresh game
        do_reset();
        enter_secret_0123();
        press(2);
        press(1);
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        model_reset();
        push_exp();
        compare_out();
        @(negedge clk);
        reset = 1'b0;
        enter_secret_0123();
        for (int i = 0; i < 4; i++) press(i);
        commit();

        for (int g = 0; g < 30; g++) random_game();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
